// File: rtl/panel_if_pkg.sv
// Shared constants, capture record and output-buffer state for the panel capture monitor.
package panel_if_pkg;

  localparam int unsigned LANES      = 12;
  localparam int unsigned CHAIN_BITS = 16;
  localparam int unsigned ROWS       = 16;
  localparam int unsigned ROW_W      = $clog2(ROWS);
  localparam int unsigned ONT_W      = 16;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned DATA_W     = LANES * CHAIN_BITS;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ROW_W-1:0]  row;
    logic [CNT_W-1:0]  bit_count;
    logic [ONT_W-1:0]  on_cycles;
    logic              err_row;
    logic              err_count;
  } cap_rec_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/panel_sync_edge.sv
// Two-flop synchroniser with optional registered rising-edge detect.
// Edge detect adds a third stage so every bus shares the same two-flop data latency.
module panel_sync_edge #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter bit           EDGE    = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

  generate
    if (EDGE) begin : g_edge
      logic [W-1:0] r_s3;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_s3 <= RST_VAL;
        else          r_s3 <= r_s2;
      end
      assign o_rise = r_s2 & ~r_s3;
    end else begin : g_no_edge
      assign o_rise = '0;
    end
  endgenerate

endmodule

// File: rtl/panel_capture.sv
// Panel-side receiver: rebuilds driver-chain shift/latch contents from the oversampled
// panel interface and presents each latched row as a record on a single-entry valid/ready port.
module panel_capture
  import panel_if_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              serial_clk,
  input  logic              latch_enable,
  input  logic              output_enable_n,
  input  logic [LANES-1:0]  serial_data_in,
  input  logic [ROWS-1:0]   row_select_n,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [DATA_W-1:0] cap_data,
  output logic [ROW_W-1:0]  cap_row,
  output logic [CNT_W-1:0]  cap_bit_count,
  output logic [ONT_W-1:0]  cap_on_cycles,
  output logic              cap_err_row,
  output logic              cap_err_count,
  output logic              overflow
);

  localparam int unsigned LC_W = $clog2(ROWS + 1);

  logic                 w_sclk_rise, w_latch_rise, w_oe_n_q;
  logic                 w_unused_sclk_q, w_unused_latch_q, w_unused_oe_rise;
  logic [LANES-1:0]     w_data_q, w_unused_data_rise;
  logic [ROWS-1:0]      w_row_n_q, w_unused_row_rise;

  panel_sync_edge #(.W(1), .RST_VAL(1'b0), .EDGE(1'b1)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .i_d(serial_clk),
    .o_q(w_unused_sclk_q), .o_rise(w_sclk_rise));

  panel_sync_edge #(.W(1), .RST_VAL(1'b0), .EDGE(1'b1)) u_sync_latch (
    .clk(clk), .reset_n(reset_n), .i_d(latch_enable),
    .o_q(w_unused_latch_q), .o_rise(w_latch_rise));

  panel_sync_edge #(.W(1), .RST_VAL(1'b1), .EDGE(1'b1)) u_sync_oe (
    .clk(clk), .reset_n(reset_n), .i_d(output_enable_n),
    .o_q(w_oe_n_q), .o_rise(w_unused_oe_rise));

  panel_sync_edge #(.W(LANES), .RST_VAL('0), .EDGE(1'b0)) u_sync_data (
    .clk(clk), .reset_n(reset_n), .i_d(serial_data_in),
    .o_q(w_data_q), .o_rise(w_unused_data_rise));

  panel_sync_edge #(.W(ROWS), .RST_VAL({ROWS{1'b1}}), .EDGE(1'b0)) u_sync_row (
    .clk(clk), .reset_n(reset_n), .i_d(row_select_n),
    .o_q(w_row_n_q), .o_rise(w_unused_row_rise));

  logic [LANES-1:0][CHAIN_BITS-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]                 r_bit_cnt, w_bit_nxt;
  logic [ONT_W-1:0]                 r_on_cnt, w_on_nxt;
  logic [LC_W-1:0]                  w_low_cnt;
  logic [ROW_W-1:0]                 w_row_idx;
  cap_rec_t                         w_new_rec, r_rec;
  cap_state_e                       r_state, w_state_nxt;
  logic                             w_load, w_drop, r_ovf;

  // Shift applies before a coincident latch, so the record sees the new bit and count.
  always_comb begin
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    if (w_sclk_rise) begin
      for (int i = 0; i < LANES; i++) begin
        w_shift_nxt[i] = {r_shift[i][CHAIN_BITS-2:0], w_data_q[i]};
      end
      w_bit_nxt = (r_bit_cnt == '1) ? r_bit_cnt : r_bit_cnt + CNT_W'(1);
    end
    w_on_nxt = (!w_oe_n_q && (r_on_cnt != '1)) ? r_on_cnt + ONT_W'(1) : r_on_cnt;
  end

  always_comb begin
    w_low_cnt = '0;
    w_row_idx = '0;
    for (int k = 0; k < ROWS; k++) begin
      if (!w_row_n_q[k]) begin
        w_low_cnt = w_low_cnt + LC_W'(1);
        w_row_idx = ROW_W'(k);
      end
    end
  end

  always_comb begin
    w_new_rec           = '0;
    w_new_rec.data      = w_shift_nxt;
    w_new_rec.err_row   = (w_low_cnt != LC_W'(1));
    w_new_rec.row       = w_new_rec.err_row ? '0 : w_row_idx;
    w_new_rec.bit_count = w_bit_nxt;
    w_new_rec.on_cycles = w_on_nxt;
    w_new_rec.err_count = (w_bit_nxt != CNT_W'(CHAIN_BITS));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_on_cnt  <= '0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_latch_rise ? '0 : w_bit_nxt;
      r_on_cnt  <= w_latch_rise ? '0 : w_on_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_latch_rise) w_state_nxt = FULL;
      FULL:    if (cap_ready && !w_latch_rise) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // A held record is replaced only when it is being consumed in the same cycle.
  always_comb begin
    w_load = 1'b0;
    w_drop = 1'b0;
    if (w_latch_rise) begin
      if (r_state == EMPTY || cap_ready) w_load = 1'b1;
      else                               w_drop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rec <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_load) r_rec <= w_new_rec;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign cap_valid     = (r_state == FULL);
  assign cap_data      = r_rec.data;
  assign cap_row       = r_rec.row;
  assign cap_bit_count = r_rec.bit_count;
  assign cap_on_cycles = r_rec.on_cycles;
  assign cap_err_row   = r_rec.err_row;
  assign cap_err_count = r_rec.err_count;
  assign overflow      = r_ovf;

endmodule
